w_mem_rd_ctrl: RTL and testbench
================================

Name: w_mem_rd_ctrl

Overview:
- Read-side counterpart of the weight-memory write path.
- Fetches weight tiles from the SYS_COL per-column weight SRAMs, in ascending address order within each tile, and streams them row-by-row to the systolic-array weight preload port over a valid/ready interface.
- Rows were stored in reversed order, so ascending reads deliver the bottom array row first, which is the order the preload shift chain needs.
- Handles 1-cycle SRAM read latency and downstream backpressure with a 3-entry return FIFO.

Parameters:
SYS_ROW, 16, rows per weight tile (power of two)
SYS_COL, 16, columns = number of weight SRAM banks
DATA_WIDTH, 16, weight element width
ADDR_WIDTH, 16, SRAM address width
MAX_TILES, 64, maximum tiles per request; TILE_WIDTH = $clog2(MAX_TILES)+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
num_tiles  in  TILE_WIDTH  tiles to read; sampled with start
base_addr  in  ADDR_WIDTH  address of row 0 of tile 0; sampled with start
w_rd_en  out  SYS_COL  per-bank read enable (all bits equal)
w_rd_addr  out  ADDR_WIDTH x SYS_COL  per-bank read address (all equal)
w_rd_data  in  DATA_WIDTH x SYS_COL  bank read data, valid 1 cycle after w_rd_en
w_valid  out  1  output row valid
w_ready  in  1  downstream accepts row
w_data  out  DATA_WIDTH x SYS_COL  output row
w_tile_last  out  1  w_data is last row of a tile
w_last  out  1  w_data is last row of the request
busy  out  1  high whenever FSM not IDLE
done  out  1  single-cycle pulse when request fully drained

Behaviour:
- Reset (async, rst=1): FSM=IDLE; counters, FIFO pointers and count, in-flight flag cleared. Outputs w_rd_en, w_valid, busy, done, w_tile_last, w_last = 0. w_rd_addr = 0. w_data content is don't-care.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - start=1 with num_tiles>0: latch num_tiles and base_addr, clear tile_cnt and row_cnt, go to READ.
  - start=1 with num_tiles=0: no reads; done pulses the next cycle; stay IDLE.
- READ:
  - Issue condition: fifo_count + inflight < 3. No combinational path from w_ready to w_rd_en.
  - On issue, w_rd_en = all ones and w_rd_addr = ADDR_WIDTH'(base + tile_cnt*SYS_ROW + row_cnt), truncated modulo 2^ADDR_WIDTH.
  - Tag per issue: tile_last = (row_cnt==SYS_ROW-1); last = tile_last && tile_cnt==num_tiles-1.
  - row_cnt increments and wraps at SYS_ROW-1; tile_cnt increments on that wrap.
  - The last issue moves the FSM to DRAIN.
- Read timing: inflight is a 1-cycle flag set on issue. w_rd_data from a cycle-N read is written into the FIFO at the end of cycle N+1, together with its tags.
- Output side:
  - w_valid = fifo_count != 0. w_data and tags come from the FIFO head.
  - Pop on w_valid && w_ready. Push and pop in the same cycle leave the count unchanged.
  - w_data is stable while w_valid && !w_ready.
- DRAIN: when fifo_count==0 and inflight==0, done=1 for one cycle and FSM returns to IDLE.
- start while busy is ignored.
- Latency: start sampled at edge 0; w_rd_en high in cycle 1; first w_valid in cycle 3.
- Throughput: with w_ready held high, one row per cycle is sustained.
- FIFO never overflows (guaranteed by the issue condition). Underflow cannot occur because pop is gated by w_valid.
- rst asserted mid-request: request is abandoned, FIFO is flushed, and no done pulse is produced.

Test Plan:
- SYS_ROW=4, SYS_COL=4, base=0x10, num_tiles=2, w_ready=1 -> w_rd_addr 0x10..0x17 on 8 consecutive cycles starting cycle 1; w_valid cycles 3..10; w_tile_last on rows 4 and 8; w_last on row 8; done in cycle 11.
- Same request, w_ready=0 for cycles 3..8 -> exactly 3 reads issued (0x10..0x12), then w_rd_en=0; first row held stable; after release all 8 rows arrive in order with no loss or duplication.
- start with num_tiles=0 -> no w_rd_en, done one cycle later, busy stays 0.
- start pulsed again during READ with a different base -> ignored; the original address sequence completes unchanged.
- rst asserted while 2 rows are in the FIFO -> w_valid=0 and busy=0 immediately; no done pulse; a new request after reset behaves as in the first scenario.
- base=0xFFFE, num_tiles=1, SYS_ROW=4, ADDR_WIDTH=16 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/w_mem_rd_ctrl_if.sv
// Weight read path bundle: SRAM bank read port plus the row stream
// towards the systolic-array preload port.
interface w_mem_rd_ctrl_if #(
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [SYS_COL-1:0]                 w_rd_en;
    logic [SYS_COL-1:0][ADDR_WIDTH-1:0] w_rd_addr;
    logic [SYS_COL-1:0][DATA_WIDTH-1:0] w_rd_data;
    logic                               w_valid;
    logic                               w_ready;
    logic [SYS_COL-1:0][DATA_WIDTH-1:0] w_data;
    logic                               w_tile_last;
    logic                               w_last;

    modport master (
        output w_rd_en, w_rd_addr, w_valid, w_data, w_tile_last, w_last,
        input  w_rd_data, w_ready
    );

    modport slave (
        input  w_rd_en, w_rd_addr, w_valid, w_data, w_tile_last, w_last,
        output w_rd_data, w_ready
    );
endinterface

// File: rtl/w_mem_rd_ctrl.sv
// Weight-memory read controller: reads weight tiles from the per-column SRAM
// banks in ascending address order and streams them out one row per beat.
module w_mem_rd_ctrl #(
    parameter int SYS_ROW    = 16,
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_TILES  = 64,
    parameter int TILE_WIDTH = $clog2(MAX_TILES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [TILE_WIDTH-1:0] num_tiles,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    w_mem_rd_ctrl_if.master       bus
);
    localparam int ROW_W = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1;
    localparam int DEPTH = 3;

    typedef logic [SYS_COL-1:0][DATA_WIDTH-1:0] row_t;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state;
    logic [TILE_WIDTH-1:0] tile_cnt, tiles;
    logic [ROW_W-1:0]      row_cnt;
    logic [ADDR_WIDTH-1:0] base, rd_addr;
    logic                  rd_en, iss_tile_last, iss_last;
    logic                  inflight, infl_tile_last, infl_last;

    row_t                  fifo_data [DEPTH];
    logic [DEPTH-1:0]      fifo_tile_last, fifo_last;
    logic [1:0]            wr_ptr, rd_ptr, count, count_nxt;

    logic                  push, pop, req, issue;
    logic [TILE_WIDTH-1:0] cur_tile, cur_tiles;
    logic [ROW_W-1:0]      cur_row;
    logic [ADDR_WIDTH-1:0] cur_base, cur_addr;
    logic                  cur_tile_last, cur_last;

    assign push = inflight;
    assign pop  = bus.w_valid && bus.w_ready;
    assign req  = (state == IDLE) && start && (num_tiles != '0);

    // The read enable is registered, so next cycle's issue is decided from the
    // occupancy the FIFO will have then; rd_en becomes next cycle's inflight.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 2'd1;
        else if (!push && pop)
            count_nxt = count - 2'd1;
    end

    always_comb begin
        cur_base  = base;
        cur_tile  = tile_cnt;
        cur_row   = row_cnt;
        cur_tiles = tiles;
        if (state == IDLE) begin
            cur_base  = base_addr;
            cur_tile  = '0;
            cur_row   = '0;
            cur_tiles = num_tiles;
        end
        cur_addr      = cur_base + ADDR_WIDTH'(cur_tile) * ADDR_WIDTH'(SYS_ROW)
                      + ADDR_WIDTH'(cur_row);
        cur_tile_last = (cur_row == ROW_W'(SYS_ROW - 1));
        cur_last      = cur_tile_last && (cur_tile == cur_tiles - TILE_WIDTH'(1));
        issue         = req || ((state == READ)
                      && (({1'b0, count_nxt} + {2'b00, rd_en}) < 3'd3));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tile_cnt       <= '0;
            row_cnt        <= '0;
            tiles          <= '0;
            base           <= '0;
            rd_en          <= 1'b0;
            rd_addr        <= '0;
            iss_tile_last  <= 1'b0;
            iss_last       <= 1'b0;
            inflight       <= 1'b0;
            infl_tile_last <= 1'b0;
            infl_last      <= 1'b0;
            fifo_tile_last <= '0;
            fifo_last      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done           <= 1'b0;
            rd_en          <= issue;
            inflight       <= rd_en;
            infl_tile_last <= iss_tile_last;
            infl_last      <= iss_last;
            count          <= count_nxt;
            if (push) begin
                fifo_tile_last[wr_ptr] <= infl_tile_last;
                fifo_last[wr_ptr]      <= infl_last;
                wr_ptr <= (wr_ptr == 2'(DEPTH - 1)) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == 2'(DEPTH - 1)) ? 2'd0 : rd_ptr + 2'd1;
            if (issue) begin
                rd_addr       <= cur_addr;
                iss_tile_last <= cur_tile_last;
                iss_last      <= cur_last;
                if (cur_tile_last) begin
                    row_cnt  <= '0;
                    tile_cnt <= cur_tile + TILE_WIDTH'(1);
                end else begin
                    row_cnt  <= cur_row + ROW_W'(1);
                    tile_cnt <= cur_tile;
                end
            end
            case (state)
                IDLE: begin
                    if (start && num_tiles == '0) begin
                        done <= 1'b1;
                    end else if (req) begin
                        tiles <= num_tiles;
                        base  <= base_addr;
                        busy  <= 1'b1;
                        state <= cur_last ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (issue && cur_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (count_nxt == '0 && !rd_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row payload is not reset; it is only observed while the FIFO holds it.
    always_ff @(posedge clk) begin
        if (push)
            fifo_data[wr_ptr] <= bus.w_rd_data;
    end

    assign bus.w_rd_en     = {SYS_COL{rd_en}};
    assign bus.w_rd_addr   = {SYS_COL{rd_addr}};
    assign bus.w_valid     = (count != '0);
    assign bus.w_data      = fifo_data[rd_ptr];
    assign bus.w_tile_last = bus.w_valid && fifo_tile_last[rd_ptr];
    assign bus.w_last      = bus.w_valid && fifo_last[rd_ptr];
endmodule

// File: tb/tb_w_mem_rd_ctrl.sv
// Bench for w_mem_rd_ctrl: SRAM bank model, table-driven and random requests
// against an address-sequence reference, plus reset and zero-tile sequences.
module tb_w_mem_rd_ctrl;
    localparam int SYS_ROW    = 4;
    localparam int SYS_COL    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int MAX_TILES  = 64;
    localparam int TILE_WIDTH = $clog2(MAX_TILES) + 1;

    typedef logic [SYS_COL-1:0][DATA_WIDTH-1:0] row_t;
    typedef struct {
        row_t             data;
        logic             tl;
        logic             l;
    } exp_t;
    typedef struct {
        logic [ADDR_WIDTH-1:0] base;
        int                    ntiles;
        int                    rmode;       // 0 ready high, 1 random, 2 low in cycles 3..8
        bit                    restart;     // pulse start again mid-request
        int                    exp_first_valid;
        int                    exp_done;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [TILE_WIDTH-1:0] num_tiles;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  busy;
    logic                  done;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];
    vec_t tbl[4];

    w_mem_rd_ctrl_if #(.SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    w_mem_rd_ctrl #(
        .SYS_ROW(SYS_ROW), .SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .MAX_TILES(MAX_TILES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .base_addr(base_addr), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] mem_word(input logic [ADDR_WIDTH-1:0] a, input int b);
        return (a * 16'd3) ^ (16'h1111 * 16'(b)) ^ 16'hA5C3;
    endfunction

    function automatic row_t exp_row(input logic [ADDR_WIDTH-1:0] a);
        row_t r;
        for (int b = 0; b < SYS_COL; b++) r[b] = mem_word(a, b);
        return r;
    endfunction

    // SRAM banks with one cycle of read latency
    always @(posedge clk) begin
        for (int b = 0; b < SYS_COL; b++)
            if (bus.w_rd_en[b]) bus.w_rd_data[b] <= mem_word(bus.w_rd_addr[b], b);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: request rows are simply base+0 .. base+N*SYS_ROW-1 (mod 2^16)
    task automatic build_model(input logic [ADDR_WIDTH-1:0] b, input int n);
        int total;
        total = n * SYS_ROW;
        q.delete();
        for (int i = 0; i < total; i++)
            q.push_back('{exp_row(ADDR_WIDTH'(b + i)), (i % SYS_ROW) == SYS_ROW - 1, i == total - 1});
    endtask

    task automatic run_req(input vec_t v);
        int   total, issued, popped, first_v, done_c;
        bit   prev_hold;
        row_t prev_data;
        exp_t e;
        total = v.ntiles * SYS_ROW;
        build_model(v.base, v.ntiles);
        issued = 0; popped = 0; first_v = 0; done_c = 0; prev_hold = 0; prev_data = '0;
        @(negedge clk);
        start = 1'b1; num_tiles = TILE_WIDTH'(v.ntiles); base_addr = v.base;
        for (int c = 1; c <= 400 && done_c == 0; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (v.restart && c == 3) begin
                start = 1'b1; num_tiles = TILE_WIDTH'(1); base_addr = 16'h9000;
            end
            if (v.restart && c == 4) start = 1'b0;
            case (v.rmode)
                0:       bus.w_ready = 1'b1;
                1:       bus.w_ready = ($urandom_range(0, 3) != 0);
                default: bus.w_ready = !(c >= 3 && c <= 8);
            endcase
            if (prev_hold) begin
                chk("HOLD_VALID", bus.w_valid, 1);
                chk("HOLD_DATA", bus.w_data, prev_data);
            end
            if (v.rmode == 0 && c <= total) chk("RD_EN_STREAM", bus.w_rd_en[0], 1);
            if (bus.w_rd_en != '0) begin
                chk("RD_EN_BANKS", bus.w_rd_en, {SYS_COL{1'b1}});
                chk("READ_IN_RANGE", issued < total, 1);
                for (int b = 0; b < SYS_COL; b++)
                    chk("RD_ADDR", bus.w_rd_addr[b], ADDR_WIDTH'(v.base + issued));
                issued++;
            end
            if (v.rmode == 2 && c == 8) chk("BP_READS", issued, 3);
            if (bus.w_valid) begin
                if (first_v == 0) first_v = c;
                if (bus.w_ready) begin
                    chk("ROW_AVAIL", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("ROW_DATA", bus.w_data, e.data);
                        chk("ROW_TILE_LAST", bus.w_tile_last, e.tl);
                        chk("ROW_LAST", bus.w_last, e.l);
                    end
                    popped++;
                end
            end
            prev_hold = bus.w_valid && !bus.w_ready;
            prev_data = bus.w_data;
            if (done) done_c = c;
            else chk("BUSY", busy, 1);
        end
        chk("DONE_SEEN", done_c != 0, 1);
        chk("ROWS_POPPED", popped, total);
        chk("READS_ISSUED", issued, total);
        if (v.exp_done > 0) chk("DONE_CYCLE", done_c, v.exp_done);
        if (v.exp_first_valid > 0) chk("FIRST_VALID", first_v, v.exp_first_valid);
        @(negedge clk);
        chk("DONE_PULSE", done, 0);
        chk("IDLE_BUSY", busy, 0);
        chk("IDLE_VALID", bus.w_valid, 0);
    endtask

    initial begin
        vec_t rv;
        tbl[0] = '{16'h0010, 2, 0, 1'b0, 3, 11};
        tbl[1] = '{16'hFFFE, 1, 0, 1'b0, 3, 7};
        tbl[2] = '{16'h0010, 2, 2, 1'b0, 3, 17};
        tbl[3] = '{16'h0040, 3, 0, 1'b1, 3, 15};

        rst = 1'b1; start = 1'b0; num_tiles = '0; base_addr = '0; bus.w_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("RST_RD_EN", bus.w_rd_en, 0);
        chk("RST_RD_ADDR", bus.w_rd_addr, 0);
        chk("RST_VALID", bus.w_valid, 0);
        chk("RST_BUSY", busy, 0);
        chk("RST_DONE", done, 0);
        chk("RST_TAGS", {bus.w_tile_last, bus.w_last}, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_req(tbl[i]);

        // Zero-tile request: only a done pulse one cycle later
        @(negedge clk);
        start = 1'b1; num_tiles = '0; base_addr = 16'h0020;
        @(negedge clk);
        start = 1'b0;
        chk("ZERO_DONE", done, 1);
        chk("ZERO_BUSY", busy, 0);
        chk("ZERO_RD_EN", bus.w_rd_en, 0);
        repeat (3) begin
            @(negedge clk);
            chk("ZERO_DONE_AFTER", done, 0);
            chk("ZERO_BUSY_AFTER", busy, 0);
            chk("ZERO_RD_EN_AFTER", bus.w_rd_en, 0);
        end

        // Reset with two rows waiting in the FIFO
        @(negedge clk);
        start = 1'b1; num_tiles = TILE_WIDTH'(2); base_addr = 16'h0010; bus.w_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.w_ready = 1'b0;
        @(negedge clk);
        chk("PRE_RST_VALID", bus.w_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("MIDRST_VALID", bus.w_valid, 0);
        chk("MIDRST_BUSY", busy, 0);
        chk("MIDRST_RD_EN", bus.w_rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("POSTRST_DONE", done, 0);
            chk("POSTRST_VALID", bus.w_valid, 0);
            chk("POSTRST_BUSY", busy, 0);
        end
        bus.w_ready = 1'b1;
        run_req(tbl[0]);

        for (int i = 0; i < 6; i++) begin
            rv.base            = ADDR_WIDTH'($urandom);
            rv.ntiles          = int'($urandom_range(1, 5));
            rv.rmode           = 1;
            rv.restart         = 1'b0;
            rv.exp_first_valid = 0;
            rv.exp_done        = 0;
            run_req(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL WATCHDOG: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
